// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   localparam int DefCntW = 16;
   localparam logic [4:0] ZeroReg = 5'd0;

   typedef enum logic {
      RUN   = 1'b0,
      HOLD1 = 1'b1
   } hazState_e;

   // x0 is hardwired to zero, so it never creates a dependency
   function automatic logic regMatch(input logic [4:0] rd, input logic [4:0] rs);
      return (rd != ZeroReg) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side fields and control outputs of the hazard controller.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
   logic [4:0]       RS1addr_ID_i;
   logic [4:0]       RS2addr_ID_i;
   logic             RS1use_ID_i;
   logic             RS2use_ID_i;
   logic             Jalr_ID_i;
   logic [4:0]       RDaddr_IDEX_i;
   logic             RegWrite_IDEX_i;
   logic             MemRead_IDEX_i;
   logic [4:0]       RDaddr_EXMEM_i;
   logic             MemRead_EXMEM_i;
   logic             BranchTaken_EX_i;
   logic             MemStall_i;
   logic             PCWrite_o;
   logic             IFIDWrite_o;
   logic             IFIDFlush_o;
   logic             NoOp_o;
   logic             PipeFreeze_o;
   logic [CNT_W-1:0] StallCnt_o;
   logic [CNT_W-1:0] FlushCnt_o;

   modport slave (
      input  RS1addr_ID_i, RS2addr_ID_i, RS1use_ID_i, RS2use_ID_i, Jalr_ID_i,
             RDaddr_IDEX_i, RegWrite_IDEX_i, MemRead_IDEX_i,
             RDaddr_EXMEM_i, MemRead_EXMEM_i, BranchTaken_EX_i, MemStall_i,
      output PCWrite_o, IFIDWrite_o, IFIDFlush_o, NoOp_o, PipeFreeze_o,
             StallCnt_o, FlushCnt_o
   );

   modport master (
      output RS1addr_ID_i, RS2addr_ID_i, RS1use_ID_i, RS2use_ID_i, Jalr_ID_i,
             RDaddr_IDEX_i, RegWrite_IDEX_i, MemRead_IDEX_i,
             RDaddr_EXMEM_i, MemRead_EXMEM_i, BranchTaken_EX_i, MemStall_i,
      input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, NoOp_o, PipeFreeze_o,
             StallCnt_o, FlushCnt_o
   );
endinterface

// File: rtl/hazard_detect.sv
// Combinational dependency matcher: need1 = one stall cycle, need2 = two.
module hazard_detect
   import hazard_pkg::*;
(
   input  logic [4:0] rs1Addr,
   input  logic [4:0] rs2Addr,
   input  logic       rs1Use,
   input  logic       rs2Use,
   input  logic       jalrId,
   input  logic [4:0] rdIdEx,
   input  logic       regWriteIdEx,
   input  logic       memReadIdEx,
   input  logic [4:0] rdExMem,
   input  logic       memReadExMem,
   output logic       need1,
   output logic       need2
);

   logic loadUse;
   logic jalrAlu;
   logic jalrLoadEx;
   logic jalrLoadMem;

   always_comb begin
      loadUse     = memReadIdEx && ((rs1Use && regMatch(rdIdEx, rs1Addr)) ||
                                    (rs2Use && regMatch(rdIdEx, rs2Addr)));
      // ALU result reaches JALR through the EX/MEM forward after one stall
      jalrAlu     = jalrId && regWriteIdEx && !memReadIdEx && regMatch(rdIdEx, rs1Addr);
      jalrLoadEx  = jalrId && memReadIdEx && regMatch(rdIdEx, rs1Addr);
      jalrLoadMem = jalrId && memReadExMem && regMatch(rdExMem, rs1Addr);
      need2       = jalrLoadEx;
      need1       = loadUse || jalrAlu || jalrLoadMem;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stall/flush/freeze sequencing plus saturating event counters.
//   state | meaning
//   RUN   | normal flow, hazards evaluated
//   HOLD1 | one forced stall left (JALR behind a load in EX)
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W = DefCntW
) (
   input logic          clk_i,
   input logic          rst_i,
   hazard_ctrl_if.slave bus
);

   hazState_e        state;
   hazState_e        stateNext;
   logic             need1;
   logic             need2;
   logic             stallEv;
   logic             flushEv;
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   hazard_detect uDetect (
      .rs1Addr      (bus.RS1addr_ID_i),
      .rs2Addr      (bus.RS2addr_ID_i),
      .rs1Use       (bus.RS1use_ID_i),
      .rs2Use       (bus.RS2use_ID_i),
      .jalrId       (bus.Jalr_ID_i),
      .rdIdEx       (bus.RDaddr_IDEX_i),
      .regWriteIdEx (bus.RegWrite_IDEX_i),
      .memReadIdEx  (bus.MemRead_IDEX_i),
      .rdExMem      (bus.RDaddr_EXMEM_i),
      .memReadExMem (bus.MemRead_EXMEM_i),
      .need1        (need1),
      .need2        (need2)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= RUN;
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         state <= stateNext;
         if (stallEv && (stallCnt != '1)) stallCnt <= stallCnt + CNT_W'(1);
         if (flushEv && (flushCnt != '1)) flushCnt <= flushCnt + CNT_W'(1);
      end
   end

   always_comb begin
      stateNext        = state;
      stallEv          = 1'b0;
      flushEv          = 1'b0;
      bus.PCWrite_o    = 1'b1;
      bus.IFIDWrite_o  = 1'b1;
      bus.IFIDFlush_o  = 1'b0;
      bus.NoOp_o       = 1'b0;
      bus.PipeFreeze_o = 1'b0;
      if (rst_i) begin
         stateNext       = RUN;
         bus.PCWrite_o   = 1'b0;
         bus.IFIDWrite_o = 1'b0;
         bus.IFIDFlush_o = 1'b1;
         bus.NoOp_o      = 1'b1;
      end else if (bus.MemStall_i) begin
         // everything downstream holds, so the FSM must hold too
         bus.PipeFreeze_o = 1'b1;
         bus.PCWrite_o    = 1'b0;
         bus.IFIDWrite_o  = 1'b0;
      end else if (bus.BranchTaken_EX_i) begin
         stateNext       = RUN;
         flushEv         = 1'b1;
         bus.IFIDFlush_o = 1'b1;
         bus.NoOp_o      = 1'b1;
      end else if ((state == HOLD1) || need2 || need1) begin
         stateNext       = ((state == RUN) && need2) ? HOLD1 : RUN;
         stallEv         = 1'b1;
         bus.PCWrite_o   = 1'b0;
         bus.IFIDWrite_o = 1'b0;
         bus.NoOp_o      = 1'b1;
      end
   end

   assign bus.StallCnt_o = stallCnt;
   assign bus.FlushCnt_o = flushCnt;

endmodule
